// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin one-hot codes, coin values and the
// coin emit FSM state encoding. Also consumed by the downstream vending FSM.
package vm_pkg;

    localparam logic [2:0] COIN_1 = 3'b001;
    localparam logic [2:0] COIN_2 = 3'b010;
    localparam logic [2:0] COIN_5 = 3'b100;

    localparam logic [7:0] VAL_1 = 8'd1;
    localparam logic [7:0] VAL_2 = 8'd2;
    localparam logic [7:0] VAL_5 = 8'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } emit_state_e;

    function automatic logic [7:0] coin_value(input logic [2:0] coin);
        case (coin)
            COIN_1:  return VAL_1;
            COIN_2:  return VAL_2;
            COIN_5:  return VAL_5;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor-side and vending-side signals of the coin acceptor.
// The optional credit output `total` exists only when COIN_TOTAL_EN is defined.
interface coin_acceptor_if;

    logic [2:0] sense;
    logic [2:0] coin_i;
    logic       reject;
`ifdef COIN_TOTAL_EN
    logic [7:0] total;
`endif

`ifdef COIN_TOTAL_EN
    modport master (output sense, input coin_i, input reject, input total);
    modport slave  (input sense, output coin_i, output reject, output total);
`else
    modport master (output sense, input coin_i, input reject);
    modport slave  (input sense, output coin_i, output reject);
`endif

endinterface

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, debounce counter and a
// one-cycle event on every debounced rising edge.
module coin_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sense,
    output logic evt
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          evt_q, evt_d;

    // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sync_d  = {sync_q[0], sense};
        level_d = level_q;
        cnt_d   = '0;
        evt_d   = 1'b0;
        // The flip happens on the DEB_CYCLES-th consecutive differing sample.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
                evt_d   = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            evt_q   <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces three sensors, arbitrates events, emits spaced
// one-hot coin pulses. Define COIN_TOTAL_EN to add the saturating `total` credit.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int GAP_CYCLES = 4
) (
    input logic             clk,
    input logic             rst,
    coin_acceptor_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [2:0] evt;
    logic       evt_multi, evt_single;

    for (genvar n = 0; n < 3; n++) begin : g_ch
        coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .sense (bus.sense[n]),
            .evt   (evt[n])
        );
    end

    assign evt_multi  = (evt & (evt - 3'd1)) != 3'd0;
    assign evt_single = (evt != 3'd0) && !evt_multi;

    emit_state_e state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend_vld_q, pend_vld_d;
    logic [2:0]    pend_coin_q, pend_coin_d;
    logic [2:0]    coin_i_q, coin_i_d;
    logic          reject_q, reject_d;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pend_vld_d  = pend_vld_q;
        pend_coin_d = pend_coin_q;
        coin_i_d    = 3'b000;
        reject_d    = evt_multi;
        case (state_q)
            IDLE: begin
                if (evt_single) begin
                    state_d  = EMIT;
                    coin_i_d = evt;
                end
            end
            EMIT, GAP: begin
                if (state_q == EMIT || gap_q != '0) begin
                    state_d = GAP;
                    gap_d   = (state_q == EMIT) ? GW'(GAP_CYCLES - 1) : gap_q - GW'(1);
                    if (evt_single) begin
                        if (pend_vld_q) begin
                            reject_d = 1'b1;
                        end else begin
                            pend_vld_d  = 1'b1;
                            pend_coin_d = evt;
                        end
                    end
                end else if (pend_vld_q) begin
                    // Last GAP cycle: the pending coin goes out; a new arrival finds the slot still full.
                    state_d    = EMIT;
                    coin_i_d   = pend_coin_q;
                    pend_vld_d = 1'b0;
                    reject_d   = reject_d | evt_single;
                end else if (evt_single) begin
                    state_d  = EMIT;
                    coin_i_d = evt;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_coin_q <= 3'b000;
            coin_i_q    <= 3'b000;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pend_vld_q  <= pend_vld_d;
            pend_coin_q <= pend_coin_d;
            coin_i_q    <= coin_i_d;
            reject_q    <= reject_d;
        end
    end

    assign bus.coin_i = coin_i_q;
    assign bus.reject = reject_q;

`ifdef COIN_TOTAL_EN
    logic [7:0] total_q, total_d;
    logic [8:0] total_sum;

    // Credit moves on the same edge the coin pulse is registered.
    always_comb begin
        total_sum = {1'b0, total_q} + {1'b0, coin_value(coin_i_d)};
        total_d   = total_sum[8] ? 8'hFF : total_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= 8'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign bus.total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor (DEB_CYCLES=4, GAP_CYCLES=4); the credit
// test runs only when COIN_TOTAL_EN is defined.
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int GAP = 4;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         cyc;
        logic [2:0] coin;
        logic       rej;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [2:0] prev_coin = 3'b000;
    exp_t sb_q[$];

    coin_acceptor_if bus ();

    coin_acceptor #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_out(input int at, input logic [2:0] coin, input logic rej);
        exp_t e;
        e.cyc  = at;
        e.coin = coin;
        e.rej  = rej;
        sb_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: any coin or reject pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        check("onehot", 32'($countones(bus.coin_i) <= 1), 32'd1);
        check("no_back_to_back", 32'((prev_coin != 3'b000) && (bus.coin_i != 3'b000)), 32'd0);
        if (bus.coin_i != 3'b000 || bus.reject) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 32'({bus.coin_i, bus.reject}), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_cycle", 32'(cyc), 32'(e.cyc));
                check("out_coin", 32'(bus.coin_i), 32'(e.coin));
                check("out_reject", 32'(bus.reject), 32'(e.rej));
            end
        end
        prev_coin = bus.coin_i;
    end

    initial begin
        int b;
        bus.sense = 3'b000;
        rst = 1'b0;
        wait_cycles(3);
        check("rst_coin", 32'(bus.coin_i), 32'd0);
        check("rst_reject", 32'(bus.reject), 32'd0);
`ifdef COIN_TOTAL_EN
        check("rst_total", 32'(bus.total), 32'd0);
`endif
        rst = 1'b1;
        wait_cycles(3);

        // Single $1 coin.
        b = cyc;
        bus.sense = 3'b001;
        expect_out(b + LAT, 3'b001, 1'b0);
        wait_cycles(12);
        bus.sense = 3'b000;
        wait_cycles(20);
        check("t1_drain", 32'(sb_q.size()), 32'd0);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 20; i++) begin
            bus.sense = (i % 2 == 0) ? 3'b010 : 3'b000;
            wait_cycles(2);
        end
        bus.sense = 3'b000;
        wait_cycles(20);
        check("t2_drain", 32'(sb_q.size()), 32'd0);

        // Simultaneous $1 and $5: both dropped, one reject.
        b = cyc;
        bus.sense = 3'b101;
        expect_out(b + LAT, 3'b000, 1'b1);
        wait_cycles(10);
        bus.sense = 3'b000;
        wait_cycles(20);
        check("t3_drain", 32'(sb_q.size()), 32'd0);

        // $2, $5 pending, $1 rejected while the slot is full.
        b = cyc;
        bus.sense = 3'b010;
        expect_out(b + LAT, 3'b010, 1'b0);
        expect_out(b + LAT + 4, 3'b000, 1'b1);
        expect_out(b + LAT + GAP + 1, 3'b100, 1'b0);
        wait_cycles(3);
        bus.sense = 3'b110;
        wait_cycles(1);
        bus.sense = 3'b111;
        wait_cycles(14);
        bus.sense = 3'b000;
        wait_cycles(20);
        check("t4_drain", 32'(sb_q.size()), 32'd0);

        // Reset in GAP with a coin pending: the pending coin vanishes silently.
        b = cyc;
        bus.sense = 3'b010;
        expect_out(b + LAT, 3'b010, 1'b0);
        wait_cycles(3);
        bus.sense = 3'b110;
        wait_cycles(8);
        rst = 1'b0;
        bus.sense = 3'b000;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(30);
        check("t5_drain", 32'(sb_q.size()), 32'd0);

`ifdef COIN_TOTAL_EN
        // 52 spaced $5 coins: credit saturates at 255.
        begin
            int exp_total = 0;
            for (int k = 1; k <= 52; k++) begin
                b = cyc;
                bus.sense = 3'b100;
                expect_out(b + LAT, 3'b100, 1'b0);
                wait_cycles(LAT + 1);
                exp_total = (exp_total + 5 > 255) ? 255 : exp_total + 5;
                check($sformatf("total_%0d", k), 32'(bus.total), 32'(exp_total));
                bus.sense = 3'b000;
                wait_cycles(14);
            end
            check("t6_drain", 32'(sb_q.size()), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
